fxyz_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively exercises the 3-input combinational function block fxyz (s = (~y & z) | (x & y)).
- Drives x/y/z through all 8 input vectors in order, waits a programmable settle time, then samples s into an 8-bit truth-table register.
- Compares each sample against an expected truth table latched at start, and reports pass/fail plus a per-vector mismatch map.
- Sits beside an fxyz instance as its on-chip self-check controller, in place of an open-loop testbench.

---
 rtl/fxyz_sweep_ctrl.sv | 132 +++++++++++++
 tb/tb_fxyz_sweep_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fxyz_sweep_ctrl.sv
// Self-check sequencer for the fxyz block: walks {x,y,z} through all eight
// vectors, samples s after a settle time and scores it against a latched truth table.
module fxyz_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       s,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [7:0] table_out,
  output logic [7:0] mismatch,
  output logic [3:0] err_count,
  output logic       pass
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0] r_state;
  logic [2:0] r_idx;
  logic [3:0] r_settle;
  logic [2:0] r_vec;
  logic [7:0] r_exp;
  logic [7:0] r_table;
  logic [7:0] r_mismatch;
  logic [3:0] r_err;
  logic       r_aborted;
  logic       r_pass;

  logic       w_busy;
  logic       w_accept;
  logic       w_mis_bit;

  assign w_busy    = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
  // abort beats a coincident start, so the start is simply not accepted
  assign w_accept  = (r_state == ST_IDLE) && start && !abort;
  assign w_mis_bit = s ^ r_exp[r_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= 3'd0;
      r_settle   <= 4'd0;
      r_vec      <= 3'd0;
      r_exp      <= 8'd0;
      r_table    <= 8'd0;
      r_mismatch <= 8'd0;
      r_err      <= 4'd0;
      r_aborted  <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_exp      <= expected;
            r_table    <= 8'd0;
            r_mismatch <= 8'd0;
            r_err      <= 4'd0;
            r_pass     <= 1'b0;
            r_aborted  <= 1'b0;
            r_idx      <= 3'd0;
            r_settle   <= 4'd0;
            r_vec      <= 3'd0;
            r_state    <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          if (abort) begin
            r_aborted <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (r_settle == SETTLE_LAST) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end

        ST_SAMPLE: begin
          if (abort) begin
            // the sample of the aborting cycle is dropped
            r_aborted <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_table[r_idx]    <= s;
            r_mismatch[r_idx] <= w_mis_bit;
            r_err             <= r_err + {3'd0, w_mis_bit};
            if (r_idx == 3'd7) begin
              r_state <= ST_DONE;
            end else begin
              r_idx    <= r_idx + 3'd1;
              r_vec    <= r_idx + 3'd1;
              r_settle <= 4'd0;
              r_state  <= ST_DRIVE;
            end
          end
        end

        ST_DONE: begin
          // r_err already includes the final vector's contribution here
          r_pass  <= (r_err == 4'd0);
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // r_vec tracks r_idx during a sweep and holds the last vector once idle
  assign {x, y, z}  = r_vec;
  assign busy       = w_busy;
  assign done       = (r_state == ST_DONE);
  assign aborted    = r_aborted;
  assign table_out  = r_table;
  assign mismatch   = r_mismatch;
  assign err_count  = r_err;
  assign pass       = r_pass;

endmodule

// File: tb/tb_fxyz_sweep_ctrl.sv
// Bench for fxyz_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) run side by
// side against a behavioural fxyz with optional faults and a truth-table model.
module tb_fxyz_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       stuck;
  logic [7:0] fault_mask;

  logic       s_w       [2];
  logic       x_w       [2];
  logic       y_w       [2];
  logic       z_w       [2];
  logic       busy_w    [2];
  logic       done_w    [2];
  logic       aborted_w [2];
  logic [7:0] table_w   [2];
  logic [7:0] mis_w     [2];
  logic [3:0] err_w     [2];
  logic       pass_w    [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic fxyz_ref(input logic [2:0] v);
    logic xx, yy, zz;
    {xx, yy, zz} = v;
    return (~yy & zz) | (xx & yy);
  endfunction

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int unsigned S = (gi == 0) ? 1 : 3;
      fxyz_sweep_ctrl #(.SETTLE(S)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .expected(expected), .s(s_w[gi]),
        .x(x_w[gi]), .y(y_w[gi]), .z(z_w[gi]),
        .busy(busy_w[gi]), .done(done_w[gi]), .aborted(aborted_w[gi]),
        .table_out(table_w[gi]), .mismatch(mis_w[gi]),
        .err_count(err_w[gi]), .pass(pass_w[gi])
      );
      assign s_w[gi] = stuck ? 1'b0
                     : (fxyz_ref({x_w[gi], y_w[gi], z_w[gi]}) ^ fault_mask[{x_w[gi], y_w[gi], z_w[gi]}]);
    end
  endgenerate

  // Full sweep on both instances, with cycle-accurate busy/done/vector checks.
  task automatic run_sweep(input string name, input logic [7:0] exp_v, input logic stk,
                           input logic [7:0] mask, input bit extra_starts, input bit scramble);
    logic [7:0] m_table, m_mis;
    int         m_err, last, vec;
    for (int v = 0; v < 8; v++)
      m_table[v] = stk ? 1'b0 : (fxyz_ref(3'(v)) ^ mask[v]);
    m_mis = m_table ^ exp_v;
    m_err = 0;
    for (int v = 0; v < 8; v++) m_err += m_mis[v];

    @(negedge clk);
    stuck = stk; fault_mask = mask; expected = exp_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 34; k++) begin
      for (int d = 0; d < 2; d++) begin
        last = 8 * (settle_of(d) + 1);
        n_assert++;
        if (busy_w[d] !== (k < last)) begin
          n_fail++;
          $display("FAIL %s busy dut%0d k=%0d got %0b want %0b", name, d, k, busy_w[d], (k < last));
        end
        n_assert++;
        if (done_w[d] !== (k == last)) begin
          n_fail++;
          $display("FAIL %s done dut%0d k=%0d got %0b want %0b", name, d, k, done_w[d], (k == last));
        end
        if (k < last) begin
          vec = k / (settle_of(d) + 1);
          n_assert++;
          if ({x_w[d], y_w[d], z_w[d]} !== 3'(vec)) begin
            n_fail++;
            $display("FAIL %s xyz dut%0d k=%0d got %0d want %0d", name, d, k,
                     {x_w[d], y_w[d], z_w[d]}, vec);
          end
        end
      end
      start = extra_starts && (k == 3 || k == 7 || k == 16);
      if (scramble) expected = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_assert++;
      if ({table_w[d], mis_w[d], err_w[d], pass_w[d], aborted_w[d]} !==
          {m_table, m_mis, 4'(m_err), (m_err == 0), 1'b0}) begin
        n_fail++;
        $display("FAIL %s result dut%0d got tbl=%h mis=%h err=%0d pass=%0b abt=%0b want tbl=%h mis=%h err=%0d pass=%0b abt=0",
                 name, d, table_w[d], mis_w[d], err_w[d], pass_w[d], aborted_w[d],
                 m_table, m_mis, m_err, (m_err == 0));
      end
    end
    $display("sweep %s exp=%h stuck=%0b mask=%h -> tbl=%h/%h mis=%h/%h err=%0d/%0d pass=%0b/%0b",
             name, exp_v, stk, mask, table_w[0], table_w[1], mis_w[0], mis_w[1],
             err_w[0], err_w[1], pass_w[0], pass_w[1]);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; expected = 8'h00; stuck = 1'b0; fault_mask = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_assert++;
      if ({x_w[d], y_w[d], z_w[d], busy_w[d], done_w[d], aborted_w[d], pass_w[d],
           table_w[d], mis_w[d], err_w[d]} !== 27'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d got busy=%0b done=%0b tbl=%h mis=%h err=%0d want all zero",
                 d, busy_w[d], done_w[d], table_w[d], mis_w[d], err_w[d]);
      end
    end
    $display("reset: state checked");
  endtask

  task automatic test_basic();
    run_sweep("basic", 8'hE2, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_mismatch();
    run_sweep("mismatch", 8'hE3, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_stuck();
    run_sweep("stuck0", 8'hE2, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sweep("b2b_starts", 8'hE2, 1'b0, 8'h00, 1'b1, 1'b0);
    run_sweep("b2b_next", 8'h1D, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    logic [7:0] exp_v, m_table, m_mis, capm;
    int         ncap, m_err;
    exp_v = 8'($urandom);
    @(negedge clk);
    stuck = 1'b0; fault_mask = 8'h00; expected = exp_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ncap = (d == 0) ? 4 : 2;
      capm = 8'((1 << ncap) - 1);
      for (int v = 0; v < 8; v++) m_table[v] = fxyz_ref(3'(v));
      m_table = m_table & capm;
      m_mis   = (m_table ^ exp_v) & capm;
      m_err   = 0;
      for (int v = 0; v < 8; v++) m_err += m_mis[v];
      n_assert++;
      if ({busy_w[d], done_w[d], aborted_w[d], pass_w[d], table_w[d], mis_w[d], err_w[d]} !==
          {1'b0, 1'b0, 1'b1, 1'b0, m_table, m_mis, 4'(m_err)}) begin
        n_fail++;
        $display("FAIL abort dut%0d got busy=%0b done=%0b abt=%0b pass=%0b tbl=%h mis=%h err=%0d want 0 0 1 0 %h %h %0d",
                 d, busy_w[d], done_w[d], aborted_w[d], pass_w[d], table_w[d], mis_w[d], err_w[d],
                 m_table, m_mis, m_err);
      end
    end
    // abort alone and abort+start in IDLE must both leave everything untouched
    abort = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      for (int d = 0; d < 2; d++) begin
        n_assert++;
        if ({busy_w[d], done_w[d], aborted_w[d], pass_w[d]} !== 4'b0010) begin
          n_fail++;
          $display("FAIL abort_idle dut%0d k=%0d got busy=%0b done=%0b abt=%0b pass=%0b want 0 0 1 0",
                   d, k, busy_w[d], done_w[d], aborted_w[d], pass_w[d]);
        end
      end
      @(negedge clk);
    end
    $display("abort: exp=%h tbl=%h/%h err=%0d/%0d", exp_v, table_w[0], table_w[1], err_w[0], err_w[1]);
    run_sweep("after_abort", 8'hE2, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    stuck = 1'b0; fault_mask = 8'h00; expected = 8'hE2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_assert++;
      if ({x_w[d], y_w[d], z_w[d], busy_w[d], done_w[d], aborted_w[d], pass_w[d],
           table_w[d], mis_w[d], err_w[d]} !== 27'd0) begin
        n_fail++;
        $display("FAIL reset_mid dut%0d got xyz=%0d busy=%0b tbl=%h mis=%h err=%0d want all zero",
                 d, {x_w[d], y_w[d], z_w[d]}, busy_w[d], table_w[d], mis_w[d], err_w[d]);
      end
    end
    $display("reset_mid: state checked");
    run_sweep("after_reset", 8'hE2, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++)
      run_sweep($sformatf("rand%0d", i), 8'($urandom), ($urandom_range(0, 3) == 0),
                (i == 0) ? 8'h00 : 8'($urandom), ($urandom_range(0, 1) == 1), 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_stuck();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
